// File: rtl/icache_refill.sv
// Direct-mapped instruction cache with combinational lookup and a word-per-beat line refill FSM.
// Optional hit/miss counters are built only when ICACHE_STATS_EN is defined; otherwise both read 0.
module icache_refill #(
    parameter int LINE_WORDS = 4,
    parameter int NUM_LINES  = 64
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic [63:0] PC,
    input  logic        FLUSH,
    output logic        icache_r,
    output logic [31:0] instruction,
    output logic        F_IAF,
    output logic        mem_req,
    output logic [63:0] mem_addr,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    input  logic        mem_err,
    output logic [31:0] hit_count,
    output logic [31:0] miss_count
);
    localparam int BW     = $clog2(LINE_WORDS);
    localparam int OFF    = 2 + BW;
    localparam int IDXW   = $clog2(NUM_LINES);
    localparam int LINE_W = 64 - OFF;

    typedef enum logic [1:0] {S_IDLE, S_FILL, S_ERR} state_t;

    logic [31:0]             data_mem [NUM_LINES*LINE_WORDS];
    logic [LINE_W-IDXW-1:0]  tag_mem  [NUM_LINES];

    state_t                state_q, state_d;
    logic [NUM_LINES-1:0]  valid_q, valid_d;
    logic [LINE_W-1:0]     line_q, line_d;
    logic [BW-1:0]         beat_q, beat_d;
    logic                  killed_q, killed_d;
    logic                  mem_req_q, mem_req_d;
    logic [63:0]           mem_addr_q, mem_addr_d;

    logic [LINE_W-1:0]      pc_line;
    logic [IDXW-1:0]        pc_idx;
    logic [BW-1:0]          pc_word;
    logic [IDXW-1:0]        fill_idx;
    logic [BW-1:0]          beat_inc;
    logic                   aligned, hit, miss_start, beat_last, data_we, line_done;

    assign pc_line  = PC[63:OFF];
    assign pc_idx   = PC[OFF+IDXW-1:OFF];
    assign pc_word  = PC[OFF-1:2];
    assign aligned  = (PC[1:0] == 2'b00);
    assign fill_idx = line_q[IDXW-1:0];
    assign beat_inc = beat_q + 1'b1;

    assign hit        = (state_q == S_IDLE) && aligned && valid_q[pc_idx]
                        && (tag_mem[pc_idx] == PC[63:OFF+IDXW]);
    assign miss_start = (state_q == S_IDLE) && aligned && !hit && !FLUSH;
    assign beat_last  = (beat_q == BW'(LINE_WORDS - 1));
    assign data_we    = (state_q == S_FILL) && mem_ack && !mem_err;
    assign line_done  = data_we && beat_last;

    assign icache_r    = hit;
    assign instruction = hit ? data_mem[{pc_idx, pc_word}] : 32'd0;
    assign F_IAF       = (state_q == S_ERR) && (pc_line == line_q);
    assign mem_req     = mem_req_q;
    assign mem_addr    = mem_addr_q;

    always_comb begin
        state_d    = state_q;
        valid_d    = valid_q;
        line_d     = line_q;
        beat_d     = beat_q;
        killed_d   = killed_q;
        mem_req_d  = mem_req_q;
        mem_addr_d = mem_addr_q;
        case (state_q)
            S_IDLE: begin
                if (miss_start) begin
                    state_d         = S_FILL;
                    line_d          = pc_line;
                    beat_d          = '0;
                    killed_d        = 1'b0;
                    mem_req_d       = 1'b1;
                    mem_addr_d      = {pc_line, {BW{1'b0}}, 2'b00};
                    // The slot is overwritten word by word, so the old occupant must stop hitting now.
                    valid_d[pc_idx] = 1'b0;
                end
            end
            S_FILL: begin
                if (FLUSH) begin
                    killed_d = 1'b1;
                end
                if (mem_ack) begin
                    if (mem_err) begin
                        state_d   = S_ERR;
                        mem_req_d = 1'b0;
                    end else if (beat_last) begin
                        state_d           = S_IDLE;
                        mem_req_d         = 1'b0;
                        valid_d[fill_idx] = !(killed_q || FLUSH);
                    end else begin
                        beat_d     = beat_inc;
                        mem_addr_d = {line_q, beat_inc, 2'b00};
                    end
                end
            end
            S_ERR: begin
                if (FLUSH || (pc_line != line_q)) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (FLUSH) begin
            valid_d = '0;
        end
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q    <= S_IDLE;
            valid_q    <= '0;
            line_q     <= '0;
            beat_q     <= '0;
            killed_q   <= 1'b0;
            mem_req_q  <= 1'b0;
            mem_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            valid_q    <= valid_d;
            line_q     <= line_d;
            beat_q     <= beat_d;
            killed_q   <= killed_d;
            mem_req_q  <= mem_req_d;
            mem_addr_q <= mem_addr_d;
        end
    end

    // Line storage is never reset; valid bits alone decide residency.
    always_ff @(posedge CLK) begin
        if (data_we) begin
            data_mem[{fill_idx, beat_q}] <= mem_rdata;
        end
        if (line_done) begin
            tag_mem[fill_idx] <= line_q[LINE_W-1:IDXW];
        end
    end

`ifdef ICACHE_STATS_EN
    logic [31:0] hit_cnt_q, hit_cnt_d, miss_cnt_q, miss_cnt_d;

    always_comb begin
        hit_cnt_d  = hit_cnt_q;
        miss_cnt_d = miss_cnt_q;
        if (hit && (hit_cnt_q != 32'hFFFF_FFFF)) begin
            hit_cnt_d = hit_cnt_q + 32'd1;
        end
        if (miss_start && (miss_cnt_q != 32'hFFFF_FFFF)) begin
            miss_cnt_d = miss_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            hit_cnt_q  <= hit_cnt_d;
            miss_cnt_q <= miss_cnt_d;
        end
    end

    assign hit_count  = hit_cnt_q;
    assign miss_count = miss_cnt_q;
`else
    assign hit_count  = 32'd0;
    assign miss_count = 32'd0;
`endif

endmodule

// File: tb/tb_icache_refill.sv
// Randomized bench for icache_refill: a residency/tag model plus a memory responder predict every cycle.
module tb_icache_refill;
    localparam int LW   = 4;
    localparam int NL   = 64;
    localparam int OFF  = 4;
    localparam int IDXW = 6;
    localparam int TAGW = 64 - OFF - IDXW;

    logic        CLK, RESET, FLUSH, mem_ack, mem_err;
    logic [63:0] PC;
    logic [31:0] mem_rdata;
    logic        icache_r, F_IAF, mem_req;
    logic [31:0] instruction, hit_count, miss_count;
    logic [63:0] mem_addr;

    icache_refill #(.LINE_WORDS(LW), .NUM_LINES(NL)) dut (
        .CLK(CLK), .RESET(RESET), .PC(PC), .FLUSH(FLUSH),
        .icache_r(icache_r), .instruction(instruction), .F_IAF(F_IAF),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack),
        .mem_rdata(mem_rdata), .mem_err(mem_err),
        .hit_count(hit_count), .miss_count(miss_count)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: which line each slot holds, plus event counts.
    bit              mv [NL];
    logic [TAGW-1:0] mt [NL];
    int              exp_hits = 0;
    int              exp_misses = 0;
    bit              in_err = 0;
    logic [63:0]     err_line;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [63:0] a);
        return {a[15:0], a[31:16]} ^ a[63:32] ^ 32'h9E37_79B9;
    endfunction

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic clear_model();
        for (int i = 0; i < NL; i++) mv[i] = 1'b0;
    endtask

    task automatic chk_stats();
`ifdef ICACHE_STATS_EN
        chk("hit_count", 64'(hit_count), 64'(exp_hits));
        chk("miss_count", 64'(miss_count), 64'(exp_misses));
`else
        chk("hit_count", 64'(hit_count), 64'd0);
        chk("miss_count", 64'(miss_count), 64'd0);
`endif
    endtask

    function automatic bit model_hit(input logic [63:0] pc);
        int idx;
        idx = int'(pc[OFF+IDXW-1:OFF]);
        return (pc[1:0] == 2'b00) && mv[idx] && (mt[idx] == pc[63:OFF+IDXW]);
    endfunction

    // One fetch of pc: hit check, or a whole refill with ack delays (dly<0 = random 0..3).
    task automatic fetch(input logic [63:0] pc, input int dly, input int err_beat, input int flush_beat);
        logic [63:0] base;
        int          idx, d;
        bit          exp_hit, killed, last;
        if (in_err) begin
            PC = pc; FLUSH = 0; mem_ack = 0; mem_err = 0;
            #1;
            chk("err_r", 64'(icache_r), 64'd0);
            chk("err_req", 64'(mem_req), 64'd0);
            if (pc[63:OFF] == err_line) begin
                chk("iaf_hold", 64'(F_IAF), 64'd1);
                step();
                return;
            end
            chk("iaf_leave", 64'(F_IAF), 64'd0);
            step();
            in_err = 0;
        end
        PC = pc; FLUSH = 0; mem_ack = 0; mem_err = 0;
        #1;
        chk_stats();
        idx     = int'(pc[OFF+IDXW-1:OFF]);
        base    = {pc[63:OFF], 4'b0000};
        exp_hit = model_hit(pc);
        chk("hit", 64'(icache_r), 64'(exp_hit));
        chk("insn", 64'(instruction), exp_hit ? 64'(mem_word(pc)) : 64'd0);
        chk("iaf_idle", 64'(F_IAF), 64'd0);
        if (exp_hit || pc[1:0] != 2'b00) begin
            if (exp_hit) exp_hits++;
            step();
            if (!exp_hit) chk("misalign_noreq", 64'(mem_req), 64'd0);
            return;
        end
        exp_misses++;
        mv[idx] = 1'b0;
        step();
        killed = 0;
        for (int b = 0; b < LW; b++) begin
            d = (dly < 0) ? int'($urandom_range(0, 3)) : dly;
            for (int w = 0; w <= d; w++) begin
                last      = (w == d);
                mem_ack   = last;
                mem_err   = last && (b == err_beat);
                mem_rdata = last ? mem_word(base + 64'(4 * b)) : $urandom;
                FLUSH     = last && (b == flush_beat);
                if (!last && $urandom_range(0, 3) == 0) PC = {$urandom, $urandom};
                #1;
                chk("req", 64'(mem_req), 64'd1);
                chk("addr", mem_addr, base + 64'(4 * b));
                chk("busy_r", 64'(icache_r), 64'd0);
                chk("busy_iaf", 64'(F_IAF), 64'd0);
                step();
            end
            mem_ack = 0; mem_err = 0; FLUSH = 0; PC = pc;
            if (b == flush_beat) begin
                clear_model();
                killed = 1;
            end
            if (b == err_beat) begin
                #1;
                chk("err_req_drop", 64'(mem_req), 64'd0);
                chk("err_iaf", 64'(F_IAF), 64'd1);
                chk("err_r", 64'(icache_r), 64'd0);
                in_err   = 1;
                err_line = {OFF'(0), pc[63:OFF]};
                err_line = pc[63:OFF];
                step();
                return;
            end
        end
        mv[idx] = !killed;
        mt[idx] = pc[63:OFF+IDXW];
    endtask

    task automatic flush_idle(input logic [63:0] pc);
        bit exp_hit;
        PC = pc; FLUSH = 1; mem_ack = 0; mem_err = 0;
        #1;
        exp_hit = model_hit(pc);
        chk("flush_hit", 64'(icache_r), 64'(exp_hit));
        if (exp_hit) exp_hits++;
        step();
        FLUSH = 0;
        clear_model();
        chk("flush_noreq", 64'(mem_req), 64'd0);
    endtask

    function automatic logic [63:0] rand_pc();
        logic [63:0] pc;
        pc = (64'($urandom_range(0, 3)) << 10) | (64'($urandom_range(0, 3)) << 4)
           | (64'($urandom_range(0, 3)) << 2);
        if ($urandom_range(0, 9) == 0) pc = pc | 64'($urandom_range(1, 3));
        if ($urandom_range(0, 3) == 0) pc = pc | 64'h8000_0000_0000_0000;
        return pc;
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int eb, fb;
        logic [63:0] pc;
        clear_model();
        RESET = 1; PC = 0; FLUSH = 0; mem_ack = 0; mem_err = 0; mem_rdata = 0;
        #1 RESET = 0;
        #2;
        chk("rst_req", 64'(mem_req), 64'd0);
        chk("rst_addr", mem_addr, 64'd0);
        chk("rst_iaf", 64'(F_IAF), 64'd0);
        chk("rst_r", 64'(icache_r), 64'd0);
        chk("rst_insn", 64'(instruction), 64'd0);
        chk_stats();
        step(); step();
        RESET = 1;

        // Cold miss with back-to-back acks, then same-cycle hits.
        fetch(64'h1000, 0, -1, -1);
        fetch(64'h1000, 0, -1, -1);
        fetch(64'h1008, 0, -1, -1);
        // Stalled memory.
        fetch(64'h2040, 3, -1, -1);
        fetch(64'h204C, 0, -1, -1);
        // Conflict eviction on index 0.
        fetch(64'h1400, -1, -1, -1);
        fetch(64'h1400, 0, -1, -1);
        fetch(64'h1000, -1, -1, -1);
        fetch(64'h1000, 0, -1, -1);
        // Bus error on beat 2, hold, then leave to a new line.
        fetch(64'h2000, 0, 2, -1);
        fetch(64'h2004, 0, -1, -1);
        fetch(64'h3000, 0, -1, -1);
        fetch(64'h3000, 0, -1, -1);
        // Flush mid-fill and flush on the final ack.
        fetch(64'h4000, 0, -1, -1);
        fetch(64'h4000, 0, -1, -1);
        fetch(64'h5000, -1, -1, 1);
        fetch(64'h4000, 0, -1, -1);
        fetch(64'h5000, 0, -1, 3);
        fetch(64'h5000, 0, -1, -1);
        fetch(64'h5000, 0, -1, -1);

        // Asynchronous reset between edges in the middle of a fill.
        PC = 64'h6000; FLUSH = 0; mem_ack = 0;
        #1;
        step();
        chk("pre_rst_req", 64'(mem_req), 64'd1);
        #1 RESET = 0;
        #1;
        chk("async_rst_req", 64'(mem_req), 64'd0);
        chk("async_rst_addr", mem_addr, 64'd0);
        clear_model();
        exp_hits = 0;
        exp_misses = 0;
        chk_stats();
        step();
        RESET = 1;
        fetch(64'h5000, 0, -1, -1);
        fetch(64'h5000, 0, -1, -1);

        for (int i = 0; i < 250; i++) begin
            pc = rand_pc();
            if (!in_err && $urandom_range(0, 9) == 0) begin
                flush_idle(pc);
            end else begin
                eb = ($urandom_range(0, 11) == 0) ? int'($urandom_range(0, 3)) : -1;
                fb = (eb < 0 && $urandom_range(0, 9) == 0) ? int'($urandom_range(0, 3)) : -1;
                fetch(pc, -1, eb, fb);
                fetch(pc, -1, -1, -1);
            end
        end
        fetch(64'h7000, 0, -1, -1);
        PC = 64'h7000;
        #1;
        chk_stats();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/icache_refill.md
Name: icache_refill

Overview:
Direct-mapped instruction cache with a line-refill state machine. It sits directly upstream of the fetch stage and supplies the instruction word and ready flag for the current fetch PC. On a miss it fetches the whole line from the memory interface using a req/ack handshake, one word per beat. Lookup is combinational, so a hit returns its instruction in the same cycle the PC is presented.

Parameters:
LINE_WORDS, 4, 32-bit words per line (power of 2, >=2)
NUM_LINES, 64, lines in cache (power of 2)

Ports:
CLK  input  1  clock, rising edge
RESET  input  1  asynchronous, active-low reset
PC  input  64  fetch address from fetch stage
FLUSH  input  1  invalidate all lines (fence.i); one-cycle pulse
icache_r  output  1  instruction valid for PC this cycle
instruction  output  32  instruction word at PC; 0 when icache_r=0
F_IAF  output  1  access fault for PC (memory returned error)
mem_req  output  1  refill beat request
mem_addr  output  64  word address of the current beat
mem_ack  input  1  beat accepted; mem_rdata valid this cycle
mem_rdata  input  32  refill data
mem_err  input  1  bus error, qualified by mem_ack
hit_count  output  32  hit counter (see Optional Feature)
miss_count  output  32  miss counter (see Optional Feature)

Behaviour:
- Address split: offset = PC[OFF-1:0] with OFF = 2 + log2(LINE_WORDS). Index = next log2(NUM_LINES) bits. Tag = PC[63:OFF+IDXW].
- Hit: state IDLE, valid[index], tag match and PC[1:0]==0. Then icache_r=1 and instruction = data[index][PC word offset], both combinational.
- Misaligned PC (PC[1:0]!=0): icache_r=0, no refill started, F_IAF=0.
- States: IDLE, FILL, ERR.
- IDLE -> FILL: on an aligned miss with FLUSH=0.
  - Latch line base {PC[63:OFF], OFF'b0} and tag/index.
  - Set beat counter to 0.
  - Increment miss_count.
- FILL:
  - mem_req=1, mem_addr = base + 4*beat. Both hold stable until mem_ack.
  - On mem_ack with mem_err=0: write mem_rdata to data[idx][beat], beat+1.
  - On the last beat's ack: write the tag, set valid (unless the fill was killed), go to IDLE. The hit is visible on the next cycle, so the miss-to-hit latency is LINE_WORDS acks + 1 cycle.
  - On mem_ack with mem_err=1: drop mem_req, leave the line invalid, go to ERR.
  - mem_req is deasserted in the cycle after the final ack. There are no back-to-back fills without passing through IDLE.
- ERR:
  - icache_r=0. F_IAF=1 while PC's line base equals the latched base.
  - Returns to IDLE when PC moves to a different line or when FLUSH=1.
- icache_r=0 throughout FILL and ERR, even if PC changes to a resident line.
- PC change mid-fill: the fill completes for the latched line. PC is re-looked-up in IDLE.
- FLUSH:
  - Clears all valid bits in the same edge.
  - During FILL it marks the fill killed: beats continue to completion, but valid is not set.
  - FLUSH in the same cycle as the final ack: the line ends invalid.
- Reset (async, RESET=0): all valid=0, state IDLE, mem_req=0, mem_addr=0, F_IAF=0, counters=0. Data arrays are not reset. Reset mid-fill abandons the transfer immediately.

Optional Feature:
ICACHE_STATS_EN.
- Defined: hit_count increments every cycle icache_r=1. miss_count increments on each IDLE->FILL transition. Both saturate at 32'hFFFF_FFFF and clear only on reset.
- Undefined: no counter registers are built; hit_count and miss_count are tied to 0.

Test Plan:
- Cold miss: reset, PC=0x1000, memory acks every cycle with words 0xA0..0xA3 -> mem_addr 0x1000,0x1004,0x1008,0x100C on successive cycles; icache_r=1, instruction=0xA0 the cycle after the 4th ack; PC=0x1008 -> 0xA2 same cycle.
- Stalled memory: mem_ack delayed 3 cycles per beat -> mem_req/mem_addr held constant across wait cycles; icache_r=0 until fill completes.
- Conflict eviction: fill 0x1000, then PC=0x1400 (same index, NUM_LINES=64) -> refill; then PC=0x1000 misses again; with ICACHE_STATS_EN, miss_count=3.
- Bus error: mem_err=1 on beat 2 of 0x2000 -> mem_req drops, F_IAF=1, icache_r=0; PC=0x3000 -> F_IAF=0, new fill starts.
- FLUSH mid-fill on 0x1000 -> all 4 beats still issued, PC=0x1000 misses afterward; resident 0x4000 also misses.
- Async reset asserted mid-FILL between edges -> mem_req=0 immediately; after release, previously resident line misses; counters read 0.
